reg_file_8x16: RTL and testbench



---
 rtl/reg_file_8x16.sv | 65 ++++++
 tb/tb_reg_file_8x16.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_8x16.sv
// Architectural register file for the 16-bit MIPS core. It has one write port and two combinational
// read ports with same-cycle write bypass, plus a debug port that shows committed state only.
module reg_file_8x16 #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned NUM_REGS   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  reg_write,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0] read_addr1,
  input  logic [ADDR_WIDTH-1:0] read_addr2,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic                  wr_en;

  // Address 0 is never written, so regs_q[0] stays at its reset value of zero.
  assign wr_en = rst_n && reg_write && (write_addr != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs_q <= '{default: '0};
    end else if (wr_en) begin
      regs_q[write_addr] <= write_data;
    end
  end

  // The bypass path only goes from write_data to read_data. Nothing feeds back into write_data.
  always_comb begin
    read_data1 = '0;
    if (rst_n && read_addr1 != '0) begin
      if (reg_write && write_addr == read_addr1) begin
        read_data1 = write_data;
      end else begin
        read_data1 = regs_q[read_addr1];
      end
    end
  end

  always_comb begin
    read_data2 = '0;
    if (rst_n && read_addr2 != '0) begin
      if (reg_write && write_addr == read_addr2) begin
        read_data2 = write_data;
      end else begin
        read_data2 = regs_q[read_addr2];
      end
    end
  end

  always_comb begin
    dbg_data = '0;
    if (rst_n && dbg_addr != '0) begin
      dbg_data = regs_q[dbg_addr];
    end
  end

endmodule

// File: tb/tb_reg_file_8x16.sv
// Self-checking bench for reg_file_8x16. It runs directed scenarios, then random traffic against an
// array-based reference model.
module tb_reg_file_8x16;
  localparam int DW = 16;
  localparam int AW = 3;
  localparam int NR = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          reg_write = 1'b0;
  logic [AW-1:0] write_addr = '0;
  logic [DW-1:0] write_data = '0;
  logic [AW-1:0] read_addr1 = '0;
  logic [AW-1:0] read_addr2 = '0;
  logic [AW-1:0] dbg_addr = '0;
  logic [DW-1:0] read_data1;
  logic [DW-1:0] read_data2;
  logic [DW-1:0] dbg_data;

  logic [DW-1:0] model [NR];
  int checks = 0;
  int errors = 0;

  reg_file_8x16 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .reg_write (reg_write),
    .write_addr(write_addr),
    .write_data(write_data),
    .read_addr1(read_addr1),
    .read_addr2(read_addr2),
    .read_data1(read_data1),
    .read_data2(read_data2),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data)
  );

  always #5 clk = ~clk;

  // Reference rules for a read port, applied to the inputs currently being driven.
  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    if (!rst_n || a == 0) return '0;
    if (reg_write && write_addr == a) return write_data;
    return model[a];
  endfunction

  function automatic logic [DW-1:0] ref_dbg(input logic [AW-1:0] a);
    if (!rst_n || a == 0) return '0;
    return model[a];
  endfunction

  // Advance one rising edge and apply the architectural update to the model. Inputs were set up
  // well before the edge, so the values seen here are the ones the DUT samples.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) model[i] = '0;
    end else if (reg_write && write_addr != 0) begin
      model[write_addr] = write_data;
    end
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    reg_write = 1'b1; write_addr = a; write_data = d;
    tick();
    reg_write = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 1; i < NR; i++) do_write(AW'(i), DW'(16'h1111 * i));
    rst_n = 1'b0; reg_write = 1'b1; write_addr = 3'd3; write_data = 16'hBEEF;
    read_addr1 = 3'd3; read_addr2 = 3'd5; dbg_addr = 3'd4;
    #1;
    checks++;
    if (read_data1 !== 16'h0) begin
      errors++; $display("FAIL reset_rd1 got %h expected 0000", read_data1);
    end
    checks++;
    if (read_data2 !== 16'h0) begin
      errors++; $display("FAIL reset_rd2 got %h expected 0000", read_data2);
    end
    checks++;
    if (dbg_data !== 16'h0) begin
      errors++; $display("FAIL reset_dbg got %h expected 0000", dbg_data);
    end
    tick();
    rst_n = 1'b1; reg_write = 1'b0;
    for (int i = 0; i < NR; i++) begin
      dbg_addr = AW'(i);
      #1;
      checks++;
      if (dbg_data !== 16'h0) begin
        errors++; $display("FAIL reset_clear r%0d got %h expected 0000", i, dbg_data);
      end
    end
  endtask

  task automatic test_basic();
    do_write(3'd5, 16'hA5A5);
    read_addr1 = 3'd5; read_addr2 = 3'd5; dbg_addr = 3'd5;
    #1;
    checks++;
    if (read_data1 !== 16'hA5A5) begin
      errors++; $display("FAIL basic_rd1 got %h expected a5a5", read_data1);
    end
    checks++;
    if (read_data2 !== 16'hA5A5) begin
      errors++; $display("FAIL basic_rd2 got %h expected a5a5", read_data2);
    end
    checks++;
    if (dbg_data !== 16'hA5A5) begin
      errors++; $display("FAIL basic_dbg got %h expected a5a5", dbg_data);
    end
  endtask

  task automatic test_r0();
    reg_write = 1'b1; write_addr = 3'd0; write_data = 16'hFFFF; read_addr1 = 3'd0; dbg_addr = 3'd0;
    #1;
    checks++;
    if (read_data1 !== 16'h0) begin
      errors++; $display("FAIL r0_same_cycle got %h expected 0000", read_data1);
    end
    tick();
    reg_write = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (read_data1 !== 16'h0 || dbg_data !== 16'h0) begin
        errors++; $display("FAIL r0_after got rd1=%h dbg=%h expected 0000", read_data1, dbg_data);
      end
      tick();
    end
  endtask

  task automatic test_bypass();
    do_write(3'd2, 16'h0010);
    reg_write = 1'b1; write_addr = 3'd2; write_data = 16'h0020;
    read_addr1 = 3'd2; read_addr2 = 3'd2; dbg_addr = 3'd2;
    #1;
    checks++;
    if (read_data1 !== 16'h0020 || read_data2 !== 16'h0020) begin
      errors++;
      $display("FAIL bypass_reads got %h/%h expected 0020", read_data1, read_data2);
    end
    checks++;
    if (dbg_data !== 16'h0010) begin
      errors++; $display("FAIL bypass_dbg_before got %h expected 0010", dbg_data);
    end
    tick();
    reg_write = 1'b0;
    #1;
    checks++;
    if (dbg_data !== 16'h0020) begin
      errors++; $display("FAIL bypass_dbg_after got %h expected 0020", dbg_data);
    end
  endtask

  task automatic test_write_disabled();
    do_write(3'd4, 16'h00FF);
    reg_write = 1'b0; write_addr = 3'd4; write_data = 16'h1234; read_addr2 = 3'd4;
    #1;
    checks++;
    if (read_data2 !== 16'h00FF) begin
      errors++; $display("FAIL wdis_before got %h expected 00ff", read_data2);
    end
    tick();
    checks++;
    if (read_data2 !== 16'h00FF) begin
      errors++; $display("FAIL wdis_after got %h expected 00ff", read_data2);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] expect_regs [NR];
    for (int i = 0; i < NR; i++) expect_regs[i] = model[i];
    expect_regs[7] = 16'h0002;
    expect_regs[6] = 16'h0003;
    do_write(3'd7, 16'h0001);
    do_write(3'd7, 16'h0002);
    do_write(3'd6, 16'h0003);
    for (int i = 0; i < NR; i++) begin
      dbg_addr = AW'(i);
      #1;
      checks++;
      if (dbg_data !== expect_regs[i]) begin
        errors++; $display("FAIL b2b r%0d got %h expected %h", i, dbg_data, expect_regs[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      rst_n      = ($urandom_range(0, 39) != 0);
      reg_write  = $urandom_range(0, 1) == 1;
      write_addr = AW'($urandom);
      write_data = DW'($urandom);
      read_addr1 = ($urandom_range(0, 3) == 0) ? write_addr : AW'($urandom);
      read_addr2 = ($urandom_range(0, 3) == 0) ? write_addr : AW'($urandom);
      dbg_addr   = AW'($urandom);
      #1;
      checks++;
      if (read_data1 !== ref_read(read_addr1) || read_data2 !== ref_read(read_addr2) ||
          dbg_data !== ref_dbg(dbg_addr)) begin
        errors++;
        $display("FAIL random[%0d] got %h/%h/%h expected %h/%h/%h", n, read_data1, read_data2,
                 dbg_data, ref_read(read_addr1), ref_read(read_addr2), ref_dbg(dbg_addr));
      end
      tick();
    end
    rst_n = 1'b1; reg_write = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NR; i++) model[i] = '0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    test_reset();
    test_basic();
    test_r0();
    test_bypass();
    test_write_disabled();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
